// File: rtl/sort_sched_ctrl.sv
// sort_sched_ctrl
// ---------------------------------------------------------------------------
// Sequencing controller for an in-place selection sort. A single FSM walks
// the outer index i and the inner index j, issues reads to a
// synchronous-read element RAM, tracks the running minimum of each inner
// pass, and writes back the swapped pair when that minimum is not already
// at position i. All RAM traffic originates here.
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : synchronous reset, active-high
//   i_start      : start request, sampled only in IDLE
//   i_num_elems  : element count n, latched when a start is accepted
//   o_rd_en      : RAM read strobe (RD_I / RD_J)
//   o_rd_addr    : RAM read address, holds its last value when idle
//   i_rd_data    : RAM read data, valid the cycle after o_rd_en
//   o_wr_en      : RAM write strobe (SWAP_A / SWAP_B)
//   o_wr_addr    : RAM write address, holds its last value when idle
//   o_wr_data    : RAM write data, holds its last value when idle
//   o_value_i    : current outer index
//   o_value_j    : current inner index
//   o_busy       : high in every state except IDLE
//   o_done       : one-cycle pulse when the sort completes
// ---------------------------------------------------------------------------
module sort_sched_ctrl #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_num_elems,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic                 o_wr_en,
    output logic [SIZE_ADDR-1:0] o_wr_addr,
    output logic [SIZE_DATA-1:0] o_wr_data,
    output logic [SIZE_ADDR-1:0] o_value_i,
    output logic [SIZE_ADDR-1:0] o_value_j,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LD_MIN,
        RD_J,
        CMP,
        SWAP_A,
        SWAP_B,
        DONE
    } state_t;

    localparam logic [SIZE_ADDR-1:0] ONE = SIZE_ADDR'(1);

    state_t state_q, state_d;

    logic [SIZE_ADDR-1:0] n_q,       n_d;
    logic [SIZE_ADDR-1:0] i_q,       i_d;
    logic [SIZE_ADDR-1:0] j_q,       j_d;
    logic [SIZE_ADDR-1:0] min_idx_q, min_idx_d;
    logic [SIZE_ADDR-1:0] rd_addr_q, rd_addr_d;
    logic [SIZE_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [SIZE_DATA-1:0] min_val_q, min_val_d;
    logic [SIZE_DATA-1:0] cur_val_q, cur_val_d;
    logic [SIZE_DATA-1:0] wr_data_q, wr_data_d;

    logic [SIZE_ADDR-1:0] n_m1;
    logic [SIZE_ADDR-1:0] i_p1;
    logic [SIZE_ADDR-1:0] j_p1;
    logic                 last_pass;
    logic                 cmp_lt;
    logic [SIZE_DATA-1:0] cmp_min_val;
    logic [SIZE_ADDR-1:0] cmp_min_idx;

    assign n_m1      = n_q - ONE;
    assign i_p1      = i_q + ONE;
    assign j_p1      = j_q + ONE;
    // The final outer pass is i = n-2; after it the last element is in place.
    assign last_pass = (i_p1 == n_m1);

    // Strict compare: an equal element never displaces the current minimum,
    // which keeps equal runs from generating useless swaps.
    assign cmp_lt      = (i_rd_data < min_val_q);
    assign cmp_min_val = cmp_lt ? i_rd_data : min_val_q;
    assign cmp_min_idx = cmp_lt ? j_q       : min_idx_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        i_d       = i_q;
        j_d       = j_q;
        min_idx_d = min_idx_q;
        min_val_d = min_val_q;
        cur_val_d = cur_val_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    n_d = i_num_elems;
                    if (i_num_elems <= ONE) begin
                        state_d = DONE;
                    end else begin
                        i_d       = '0;
                        rd_addr_d = '0;
                        state_d   = RD_I;
                    end
                end
            end
            RD_I: begin
                state_d = LD_MIN;
            end
            LD_MIN: begin
                cur_val_d = i_rd_data;
                min_val_d = i_rd_data;
                min_idx_d = i_q;
                j_d       = i_p1;
                rd_addr_d = i_p1;
                state_d   = RD_J;
            end
            RD_J: begin
                state_d = CMP;
            end
            CMP: begin
                min_val_d = cmp_min_val;
                min_idx_d = cmp_min_idx;
                if (j_q < n_m1) begin
                    j_d       = j_p1;
                    rd_addr_d = j_p1;
                    state_d   = RD_J;
                end else if (cmp_min_idx != i_q) begin
                    wr_addr_d = i_q;
                    wr_data_d = cmp_min_val;
                    state_d   = SWAP_A;
                end else if (last_pass) begin
                    state_d = DONE;
                end else begin
                    i_d       = i_p1;
                    rd_addr_d = i_p1;
                    state_d   = RD_I;
                end
            end
            SWAP_A: begin
                // The old element at i goes to where the minimum was found.
                wr_addr_d = min_idx_q;
                wr_data_d = cur_val_q;
                state_d   = SWAP_B;
            end
            SWAP_B: begin
                if (last_pass) begin
                    state_d = DONE;
                end else begin
                    i_d       = i_p1;
                    rd_addr_d = i_p1;
                    state_d   = RD_I;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            min_idx_q <= '0;
            min_val_q <= '0;
            cur_val_q <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            i_q       <= i_d;
            j_q       <= j_d;
            min_idx_q <= min_idx_d;
            min_val_q <= min_val_d;
            cur_val_q <= cur_val_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Strobes decode straight from the state register, so they can never
    // overlap and drop to zero on the cycle right after a reset.
    assign o_rd_en   = (state_q == RD_I) || (state_q == RD_J);
    assign o_wr_en   = (state_q == SWAP_A) || (state_q == SWAP_B);
    assign o_rd_addr = rd_addr_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_value_i = i_q;
    assign o_value_j = j_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_sort_sched_ctrl.sv
module tb_sort_sched_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] value_i;
    logic [AW-1:0] value_j;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    sort_sched_ctrl #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_num_elems (num),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_value_i   (value_i),
        .o_value_j   (value_j),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Element RAM: synchronous read, plus a bench-side load port.
    logic [DW-1:0] mem [256];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour, generated from the algorithm itself.
    typedef struct {
        bit            busy;
        bit            dn;
        bit            rd;
        logic [AW-1:0] ra;
        bit            wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            ci;
        logic [AW-1:0] vi;
        bit            cj;
        logic [AW-1:0] vj;
    } rec_t;

    rec_t          q[$];
    logic [DW-1:0] model_arr [256];
    int            model_swaps;

    function automatic void add(bit b, bit d, bit r, logic [AW-1:0] ra, bit w,
                                logic [AW-1:0] wa, logic [DW-1:0] wd,
                                bit ci, logic [AW-1:0] vi, bit cj, logic [AW-1:0] vj);
        rec_t e;
        e.busy = b; e.dn = d; e.rd = r; e.ra = ra; e.wr = w; e.wa = wa; e.wd = wd;
        e.ci = ci; e.vi = vi; e.cj = cj; e.vj = vj;
        q.push_back(e);
    endfunction

    function automatic void build_trace(int n);
        logic [DW-1:0] a [256];
        logic [DW-1:0] mv, t;
        int mi;
        for (int k = 0; k < 256; k++) a[k] = mem[k];
        model_swaps = 0;
        if (n <= 1) begin
            add(1, 1, 0, '0, 0, '0, '0, 0, '0, 0, '0);
        end else begin
            for (int i = 0; i <= n - 2; i++) begin
                add(1, 0, 1, 8'(i), 0, '0, '0, 1, 8'(i), 0, '0);
                add(1, 0, 0, '0, 0, '0, '0, 1, 8'(i), 0, '0);
                mv = a[i];
                mi = i;
                for (int j = i + 1; j <= n - 1; j++) begin
                    add(1, 0, 1, 8'(j), 0, '0, '0, 1, 8'(i), 1, 8'(j));
                    add(1, 0, 0, '0, 0, '0, '0, 1, 8'(i), 1, 8'(j));
                    if (a[j] < mv) begin
                        mv = a[j];
                        mi = j;
                    end
                end
                if (mi != i) begin
                    add(1, 0, 0, '0, 1, 8'(i), mv, 1, 8'(i), 0, '0);
                    add(1, 0, 0, '0, 1, 8'(mi), a[i], 1, 8'(i), 0, '0);
                    t = a[i]; a[i] = a[mi]; a[mi] = t;
                    model_swaps++;
                end
            end
            add(1, 1, 0, '0, 0, '0, '0, 1, 8'(n - 2), 0, '0);
        end
        for (int k = 0; k < 256; k++) model_arr[k] = a[k];
    endfunction

    // Compare process: every cycle, DUT outputs against the expected trace.
    bit            chk_on = 0;
    logic [39:0]   wlog[$];
    int            rd_count = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            if (wr_en) wlog.push_back({wr_addr, wr_data});
            if (rd_en) rd_count++;
            if (q.size() > 0) begin
                rec_t r;
                r = q.pop_front();
                chk("busy", 40'(busy), 40'(r.busy));
                chk("done", 40'(done), 40'(r.dn));
                chk("rd_en", 40'(rd_en), 40'(r.rd));
                chk("wr_en", 40'(wr_en), 40'(r.wr));
                if (r.rd) chk("rd_addr", 40'(rd_addr), 40'(r.ra));
                if (r.wr) begin
                    chk("wr_addr", 40'(wr_addr), 40'(r.wa));
                    chk("wr_data", 40'(wr_data), 40'(r.wd));
                end
                if (r.ci) chk("value_i", 40'(value_i), 40'(r.vi));
                if (r.cj) chk("value_j", 40'(value_j), 40'(r.vj));
            end else begin
                chk("idle_busy", 40'(busy), 40'(0));
                chk("idle_done", 40'(done), 40'(0));
                chk("idle_rd_en", 40'(rd_en), 40'(0));
                chk("idle_wr_en", 40'(wr_en), 40'(0));
            end
        end
    end

    // All main-thread tasks start and end at posedge + #1.
    task automatic load(input int n, input logic [DW-1:0] v [16]);
        for (int k = 0; k < n; k++) begin
            ld_en = 1'b1; ld_addr = 8'(k); ld_data = v[k];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic start_sort(input int n);
        wlog.delete();
        rd_count = 0;
        start = 1'b1;
        num = 8'(n);
        @(posedge clk); #1;
        build_trace(n);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k, input int mid);
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (done) break;
            if (k == mid) begin start = 1'b1; num = 8'd3; end
            if (k == mid + 1) start = 1'b0;
            if (k >= 4000) begin
                chk("done_timeout", 40'(k), 40'(0));
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("trace_consumed", 40'(q.size()), 40'(0));
        q.delete();
    endtask

    task automatic check_ram(input int n, input string tag);
        for (int k = 0; k < n; k++) chk({tag, "_model"}, 40'(mem[k]), 40'(model_arr[k]));
        for (int k = 0; k + 1 < n; k++) chk({tag, "_ascending"}, 40'(mem[k] <= mem[k + 1]), 40'(1));
        chk({tag, "_writes"}, 40'(wlog.size()), 40'(2 * model_swaps));
    endtask

    logic [DW-1:0] v [16];
    int            k;
    int            n;

    initial begin
        rst = 1'b1; start = 1'b0; num = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 40'(busy), 40'(0));
        chk("rst_done", 40'(done), 40'(0));
        chk("rst_rd_en", 40'(rd_en), 40'(0));
        chk("rst_wr_en", 40'(wr_en), 40'(0));
        chk("rst_value_i", 40'(value_i), 40'(0));
        chk("rst_value_j", 40'(value_j), 40'(0));
        rst = 1'b0;
        chk_on = 1;
        @(posedge clk); #1;

        // n=4, [3,1,2,0]
        v = '{default: '0};
        v[0] = 3; v[1] = 1; v[2] = 2; v[3] = 0;
        load(4, v);
        start_sort(4);
        chk("n4_trace_len", 40'(q.size()), 40'(21));
        wait_done(k, -1);
        chk("n4_done_cycle", 40'(k), 40'(21));
        chk("n4_nwrites", 40'(wlog.size()), 40'(2));
        if (wlog.size() == 2) begin
            chk("n4_write0", wlog[0], {8'd0, 32'd0});
            chk("n4_write1", wlog[1], {8'd3, 32'd3});
        end
        for (int x = 0; x < 4; x++) chk("n4_ram", 40'(mem[x]), 40'(x));

        // n=2, equal values: no swap
        v[0] = 5; v[1] = 5;
        load(2, v);
        start_sort(2);
        wait_done(k, -1);
        chk("n2_done_cycle", 40'(k), 40'(5));
        chk("n2_nwrites", 40'(wlog.size()), 40'(0));

        // n=1 and n=0: immediate done, no RAM access
        for (int m = 1; m >= 0; m--) begin
            start_sort(m);
            wait_done(k, -1);
            chk("small_done_cycle", 40'(k), 40'(1));
            chk("small_reads", 40'(rd_count), 40'(0));
            chk("small_writes", 40'(wlog.size()), 40'(0));
        end

        // start held high through DONE: ignored in DONE, restarts from IDLE
        wlog.delete(); rd_count = 0;
        start = 1'b1; num = 8'd0;
        @(posedge clk); #1;
        build_trace(0);
        add(0, 0, 0, '0, 0, '0, '0, 0, '0, 0, '0);
        build_trace(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_trace_consumed", 40'(q.size()), 40'(0));
        chk("held_reads", 40'(rd_count), 40'(0));

        // n=8 descending, with a stray start and count change mid-run
        for (int x = 0; x < 8; x++) v[x] = 32'(7 - x);
        load(8, v);
        start_sort(8);
        chk("n8_model_swaps", 40'(model_swaps), 40'(4));
        wait_done(k, 10);
        num = '0;
        chk("n8_nwrites", 40'(wlog.size()), 40'(8));
        for (int x = 0; x < 8; x++) chk("n8_ram", 40'(mem[x]), 40'(x));

        // reset during SWAP_A of the n=4 case
        v[0] = 3; v[1] = 1; v[2] = 2; v[3] = 0;
        load(4, v);
        start_sort(4);
        repeat (8) @(posedge clk);
        #1;
        chk("swapa_wr_en", 40'(wr_en), 40'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        chk("arst_busy", 40'(busy), 40'(0));
        chk("arst_done", 40'(done), 40'(0));
        chk("arst_rd_en", 40'(rd_en), 40'(0));
        chk("arst_wr_en", 40'(wr_en), 40'(0));
        chk("arst_value_i", 40'(value_i), 40'(0));
        chk("arst_value_j", 40'(value_j), 40'(0));
        chk("arst_rd_addr", 40'(rd_addr), 40'(0));
        chk("arst_wr_addr", 40'(wr_addr), 40'(0));
        chk("arst_wr_data", 40'(wr_data), 40'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("arst_nwrites", 40'(wlog.size()), 40'(1));
        chk("arst_ram3", 40'(mem[3]), 40'(0));
        start_sort(4);
        wait_done(k, -1);
        check_ram(4, "after_rst");
        for (int x = 0; x < 4; x++) chk("after_rst_lit", 40'(mem[x]), 40'((x == 0) ? 0 : x - 1));

        // randomized runs
        for (int run = 0; run < 200; run++) begin
            n = $urandom_range(2, 16);
            for (int x = 0; x < 16; x++)
                v[x] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            load(n, v);
            start_sort(n);
            wait_done(k, -1);
            check_ram(n, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_sched_ctrl.md
Name: sort_sched_ctrl

Overview:
- Sequencing controller for the in-place selection-sort datapath.
- Generates the outer index i and the inner index j, issues element reads to a synchronous-read RAM, and tracks the running minimum.
- Performs the swap write-back at the end of each inner pass.
- Sits between the top-level start/done handshake and the element RAM, replacing free-running index counters with one FSM owning all RAM traffic.

Parameters:
- SIZE_ADDR, 8, width of element indices, RAM address and element count.
- SIZE_DATA, 32, element width; unsigned compare.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  start request; sampled only in IDLE.
- i_num_elems  input  SIZE_ADDR  element count n, latched on accepted start.
- o_rd_en  output  1  RAM read strobe.
- o_rd_addr  output  SIZE_ADDR  RAM read address.
- i_rd_data  input  SIZE_DATA  RAM read data, valid the cycle after o_rd_en.
- o_wr_en  output  1  RAM write strobe.
- o_wr_addr  output  SIZE_ADDR  RAM write address.
- o_wr_data  output  SIZE_DATA  RAM write data.
- o_value_i  output  SIZE_ADDR  current outer index.
- o_value_j  output  SIZE_ADDR  current inner index.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the sort completes.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - State returns to IDLE.
  - o_value_i, o_value_j, the min index, min value, current value and latched n all clear to 0.
  - o_rd_en, o_wr_en, o_busy and o_done are 0.
  - Reset mid-sort aborts immediately; no further RAM access occurs.
- States: IDLE, RD_I, LD_MIN, RD_J, CMP, SWAP_A, SWAP_B, DONE.
- IDLE:
  - On i_start, latch n.
  - If n<=1, go to DONE; no RAM access.
  - Otherwise set i=0 and go to RD_I.
- RD_I: o_rd_en=1, o_rd_addr=i; go to LD_MIN.
- LD_MIN: cur_val=min_val=i_rd_data, min_idx=i, j=i+1; go to RD_J.
- RD_J: o_rd_en=1, o_rd_addr=j; go to CMP.
- CMP:
  - If i_rd_data < min_val (strict, unsigned), set min_val=i_rd_data and min_idx=j. Equal values never displace the minimum.
  - If j < n-1: j=j+1, go to RD_J.
  - Else if min_idx != i: go to SWAP_A.
  - Else go to NEXT (see below).
- SWAP_A: o_wr_en=1, o_wr_addr=i, o_wr_data=min_val.
- SWAP_B: o_wr_en=1, o_wr_addr=min_idx, o_wr_data=cur_val; then go to NEXT.
- NEXT (folded into the CMP/SWAP_B transition, no extra cycle):
  - If i+1 == n-1, go to DONE.
  - Else i=i+1, go to RD_I.
- DONE: o_done=1 for exactly one cycle; go to IDLE.
- Strobes: o_rd_en and o_wr_en are never both high. Outside their states both are 0, and addr/data hold their last values.
- i_start while busy is ignored. i_start in the DONE cycle is ignored. i_start held high in IDLE after DONE starts a new sort.
- i_num_elems changes while busy have no effect.
- Index arithmetic is SIZE_ADDR-bit. Maximum n = 2^SIZE_ADDR - 1; indices never wrap within that range.
- Cycle cost per outer pass: 2 + 2*(n-1-i), plus 2 if a swap occurs. DONE adds 1.
- o_value_j holds its last value outside the inner loop.

Test Plan:
- n=4, RAM=[3,1,2,0], start pulse:
  - Exactly 2 writes: (0←0), (3←3).
  - Final RAM=[0,1,2,3].
  - o_done pulses in cycle 21, counting the first RD_I cycle as 1.
  - o_busy is high in cycles 1–21.
- n=2, RAM=[5,5]: no write occurs (equal values); o_done pulses in cycle 5.
- n=1, then n=0: o_done pulses in the cycle after start; no o_rd_en or o_wr_en ever asserts.
- n=8, RAM=[7..0] descending:
  - Final RAM=[0..7].
  - 4 swaps, 8 writes in total.
  - i_start pulsed mid-run has no effect.
- i_rst asserted during SWAP_A of the n=4 case:
  - Next cycle: IDLE, all outputs 0, no SWAP_B write.
  - A new start with n=4 completes correctly.
- Random n in 2..16 with random data, 200 runs:
  - Final RAM is an ascending permutation of the input.
  - Write count is 2×(number of swaps).
  - o_done is always a single-cycle pulse.
